stopwatch_ctrl: RTL and testbench

//  Single-clock control FSM for the stopwatch datapath. Synchronises and debounces the raw

---
 rtl/stopwatch_ctrl_if.sv | 32 +++
 rtl/stopwatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: tick strobes, raw buttons/switches towards the
// controller and the timer/display control outputs coming back.
//   master : stimulus side (clock divider, buttons, switches) and consumer of the controls
//   slave  : stopwatch_ctrl
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       tick_blink;
  logic       tick_sample;
  logic       btn_pause;
  logic       btn_reset;
  logic       sw_adj;
  logic       sw_sel;
  logic       count_en;
  logic       clr;
  logic       adj_min;
  logic       adj_sec;
  logic [3:0] digit_blank;
  logic [1:0] state;

  modport master (
    output tick_1hz, tick_2hz, tick_blink, tick_sample,
    output btn_pause, btn_reset, sw_adj, sw_sel,
    input  count_en, clr, adj_min, adj_sec, digit_blank, state
  );

  modport slave (
    input  tick_1hz, tick_2hz, tick_blink, tick_sample,
    input  btn_pause, btn_reset, sw_adj, sw_sel,
    output count_en, clr, adj_min, adj_sec, digit_blank, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM. Synchronises and debounces the PAUSE/RESET buttons,
// synchronises the ADJ/SEL switches and turns the divider tick strobes into
// one-cycle count enables and a clear pulse for the timer/display block.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - stopwatch_ctrl_if.slave: tick_1hz/2hz/blink/sample, btn_pause,
//          btn_reset, sw_adj, sw_sel in; count_en, clr, adj_min, adj_sec,
//          digit_blank[3:0], state[1:0] out (all outputs registered)
module stopwatch_ctrl #(
  parameter int unsigned DEB_SAMPLES = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_PAUSED = 2'b01,
    ST_ADJUST = 2'b10
  } state_e;

  localparam int unsigned CW = $clog2(DEB_SAMPLES + 1);

  // Synchroniser chains, bit order {sel, adj, reset, pause}
  logic [3:0] raw;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_s;

  assign raw    = {bus.sw_sel, bus.sw_adj, bus.btn_reset, bus.btn_pause};
  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [1:0] btn_s;
  logic       adj_s;
  logic       sel_s;

  assign btn_s = sync_s[1:0];
  assign adj_s = sync_s[2];
  assign sel_s = sync_s[3];

  // Debounce: the DEB_SAMPLES-th consecutive differing sample commits the level
  logic [CW-1:0] deb_cnt_q [2];
  logic [1:0]    stable_q;
  logic [1:0]    stable_dly_q;
  logic [1:0]    press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
    end else begin
      stable_dly_q <= stable_q;
      if (bus.tick_sample) begin
        for (int unsigned b = 0; b < 2; b++) begin
          if (btn_s[b] != stable_q[b]) begin
            if (deb_cnt_q[b] == CW'(DEB_SAMPLES - 1)) begin
              stable_q[b]  <= btn_s[b];
              deb_cnt_q[b] <= '0;
            end else begin
              deb_cnt_q[b] <= deb_cnt_q[b] + 1'b1;
            end
          end else begin
            deb_cnt_q[b] <= '0;
          end
        end
      end
    end
  end

  assign press = stable_q & ~stable_dly_q;

  logic pause_press;
  logic reset_press;

  assign pause_press = press[0];
  assign reset_press = press[1];

  // Control FSM
  state_e     state_q, state_d;
  logic       phase_q, phase_d;
  logic       count_en_q, count_en_d;
  logic       clr_q, clr_d;
  logic       adj_min_q, adj_min_d;
  logic       adj_sec_q, adj_sec_d;
  logic [3:0] blank_q, blank_d;

  always_comb begin
    state_d = state_q;
    if (reset_press) begin
      state_d = state_q;
    end else if (adj_s && state_q != ST_ADJUST) begin
      state_d = ST_ADJUST;
    end else if (state_q == ST_ADJUST && !adj_s) begin
      state_d = ST_RUN;
    end else if (pause_press) begin
      case (state_q)
        ST_RUN:    state_d = ST_PAUSED;
        ST_PAUSED: state_d = ST_RUN;
        default:   state_d = state_q;
      endcase
    end

    // Phase only runs while staying in ADJUST; entry and all other states force 0
    if (state_q == ST_ADJUST && state_d == ST_ADJUST) phase_d = phase_q ^ bus.tick_blink;
    else                                              phase_d = 1'b0;

    // Increment source follows the pre-transition state; a clear suppresses it
    case (state_q)
      ST_RUN:    count_en_d = bus.tick_1hz;
      ST_ADJUST: count_en_d = bus.tick_2hz;
      default:   count_en_d = 1'b0;
    endcase
    count_en_d = count_en_d & ~reset_press;

    clr_d = reset_press;

    // Decoded from the next state so these line up with the state output
    adj_min_d = (state_d == ST_ADJUST) &  sel_s;
    adj_sec_d = (state_d == ST_ADJUST) & ~sel_s;
    if (state_d == ST_ADJUST && phase_d) blank_d = sel_s ? 4'b1100 : 4'b0011;
    else                                 blank_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      phase_q    <= 1'b0;
      count_en_q <= 1'b0;
      clr_q      <= 1'b0;
      adj_min_q  <= 1'b0;
      adj_sec_q  <= 1'b0;
      blank_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      count_en_q <= count_en_d;
      clr_q      <= clr_d;
      adj_min_q  <= adj_min_d;
      adj_sec_q  <= adj_sec_d;
      blank_q    <= blank_d;
    end
  end

  assign bus.count_en    = count_en_q;
  assign bus.clr         = clr_q;
  assign bus.adj_min     = adj_min_q;
  assign bus.adj_sec     = adj_sec_q;
  assign bus.digit_blank = blank_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed testbench for stopwatch_ctrl (DEB_SAMPLES=4, SYNC_STAGES=2).
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .DEB_SAMPLES (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int base_en;
  int base_clr;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (sw_if.count_en === 1'b1) en_cnt++;
    if (sw_if.clr === 1'b1)      clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 0: tick_1hz, 1: tick_2hz, 2: tick_blink; leaves the result of the strobe edge visible
  task automatic pulse(input int which);
    case (which)
      0: sw_if.tick_1hz   = 1'b1;
      1: sw_if.tick_2hz   = 1'b1;
      default: sw_if.tick_blink = 1'b1;
    endcase
    step(1);
    sw_if.tick_1hz   = 1'b0;
    sw_if.tick_2hz   = 1'b0;
    sw_if.tick_blink = 1'b0;
  endtask

  task automatic sample(input int n);
    repeat (n) begin
      sw_if.tick_sample = 1'b1;
      step(1);
      sw_if.tick_sample = 1'b0;
      step(1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b0;
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_2hz    = 1'b0;
    sw_if.tick_blink  = 1'b0;
    sw_if.tick_sample = 1'b0;
    sw_if.btn_pause   = 1'b0;
    sw_if.btn_reset   = 1'b0;
    sw_if.sw_adj      = 1'b0;
    sw_if.sw_sel      = 1'b0;

    // T1: reset values, then 5 run ticks
    step(3);
    check("rst_state", sw_if.state, 2'b00);
    check("rst_count_en", sw_if.count_en, 1'b0);
    check("rst_clr", sw_if.clr, 1'b0);
    check("rst_blank", sw_if.digit_blank, 4'b0000);
    check("rst_adj", {sw_if.adj_min, sw_if.adj_sec}, 2'b00);
    rst = 1'b1;
    step(2);
    base_en = en_cnt;
    for (int i = 0; i < 5; i++) begin
      pulse(0);
      check("t1_en_on", sw_if.count_en, 1'b1);
      step(1);
      check("t1_en_off", sw_if.count_en, 1'b0);
      step(2);
    end
    check("t1_en_total", en_cnt - base_en, 5);
    check("t1_state", sw_if.state, 2'b00);

    // T2: bouncing pause button, then a clean press
    for (int i = 0; i < 3; i++) begin
      sw_if.btn_pause = 1'b1;
      step(2);
      sample(2);
      sw_if.btn_pause = 1'b0;
      step(2);
      sample(1);
    end
    check("t2_bounce", sw_if.state, 2'b00);
    sw_if.btn_pause = 1'b1;
    step(2);
    sample(3);
    check("t2_3samples", sw_if.state, 2'b00);
    sample(1);
    check("t2_paused", sw_if.state, 2'b01);
    sw_if.btn_pause = 1'b0;
    step(2);
    sample(4);
    check("t2_release", sw_if.state, 2'b01);
    base_en = en_cnt;
    pulse(0);
    check("t2_paused_en", sw_if.count_en, 1'b0);
    step(2);
    check("t2_paused_total", en_cnt - base_en, 0);
    sw_if.btn_pause = 1'b1;
    step(2);
    sample(4);
    check("t2_resume", sw_if.state, 2'b00);
    sw_if.btn_pause = 1'b0;
    step(2);
    sample(4);

    // T3: adjust mode, minutes then seconds
    sw_if.sw_adj = 1'b1;
    sw_if.sw_sel = 1'b1;
    step(2);
    check("t3_sync_lat", sw_if.state, 2'b00);
    step(1);
    check("t3_adjust", sw_if.state, 2'b10);
    check("t3_adj_min", {sw_if.adj_min, sw_if.adj_sec}, 2'b10);
    check("t3_blank0", sw_if.digit_blank, 4'b0000);
    base_en = en_cnt;
    for (int i = 0; i < 4; i++) begin
      pulse(1);
      check("t3_en_2hz", sw_if.count_en, 1'b1);
      step(1);
    end
    check("t3_en_total", en_cnt - base_en, 4);
    pulse(0);
    check("t3_no_1hz", sw_if.count_en, 1'b0);
    pulse(2);
    check("t3_blink1", sw_if.digit_blank, 4'b1100);
    pulse(2);
    check("t3_blink0", sw_if.digit_blank, 4'b0000);
    pulse(2);
    check("t3_blink1b", sw_if.digit_blank, 4'b1100);
    sw_if.sw_sel = 1'b0;
    step(2);
    check("t3_sel_lat", sw_if.digit_blank, 4'b1100);
    step(1);
    check("t3_sec_mask", sw_if.digit_blank, 4'b0011);
    check("t3_adj_sec", {sw_if.adj_min, sw_if.adj_sec}, 2'b01);

    // T5: async reset mid-blink in ADJUST
    base_clr = clr_cnt;
    #2;
    rst = 1'b0;
    #1;
    check("t5_state", sw_if.state, 2'b00);
    check("t5_blank", sw_if.digit_blank, 4'b0000);
    check("t5_adj", {sw_if.adj_min, sw_if.adj_sec}, 2'b00);
    check("t5_en", sw_if.count_en, 1'b0);
    step(1);
    rst = 1'b1;
    step(2);
    check("t5_rel_run", sw_if.state, 2'b00);
    step(1);
    check("t5_reenter", sw_if.state, 2'b10);
    check("t5_phase0", sw_if.digit_blank, 4'b0000);
    check("t5_adj_sec", {sw_if.adj_min, sw_if.adj_sec}, 2'b01);
    check("t5_no_clr", clr_cnt - base_clr, 0);
    sw_if.sw_adj = 1'b0;
    step(3);
    check("t5_exit", sw_if.state, 2'b00);
    check("t5_exit_adj", {sw_if.adj_min, sw_if.adj_sec}, 2'b00);

    // T4: reset + pause press in the same cycle, with a 1 Hz tick alongside
    base_clr = clr_cnt;
    base_en  = en_cnt;
    sw_if.btn_pause = 1'b1;
    sw_if.btn_reset = 1'b1;
    step(2);
    sample(3);
    sw_if.tick_sample = 1'b1;
    step(1);
    sw_if.tick_sample = 1'b0;
    sw_if.tick_1hz    = 1'b1;
    step(1);
    sw_if.tick_1hz = 1'b0;
    check("t4_clr", sw_if.clr, 1'b1);
    check("t4_en_masked", sw_if.count_en, 1'b0);
    check("t4_state", sw_if.state, 2'b00);
    step(1);
    check("t4_clr_off", sw_if.clr, 1'b0);
    check("t4_pause_drop", sw_if.state, 2'b00);
    check("t4_en_total", en_cnt - base_en, 0);

    // T6: reset button held for 1000 sample strobes
    sw_if.btn_pause = 1'b0;
    sample(1000);
    sw_if.btn_reset = 1'b0;
    step(2);
    sample(4);
    check("t6_one_clr", clr_cnt - base_clr, 1);
    check("t6_state", sw_if.state, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
